rpn_stack_master: RTL and testbench

Initiator-side controller for the 4-bit LIFO stack port. It issues the stack's EN/RW push and pop commands and captures popped data. A reverse-Polish token stream (operands and operators) is evaluated on the external LIFO, and the final value is returned through a valid/ready result handshake. It sits between the token source and the LIFO instance, and tracks stack depth itself so that it never issues an illegal push or pop.

---
 rtl/rpn_stack_master_if.sv | 32 +++
 rtl/rpn_stack_master.sv | 193 +++++++++++++++++++
 tb/tb_rpn_stack_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_master_if.sv
// Bundle of the token, LIFO-command and result channels of the RPN stack master.
// The master modport is the controller's view; the slave modport is the environment's view.
interface rpn_stack_master_if #(
  parameter int unsigned W = 4
);
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_is_op;
  logic [W-1:0] tok_data;

  logic         stk_en;
  logic         stk_rw;
  logic [W-1:0] stk_din;
  logic [W-1:0] stk_dout;
  logic         stk_full;
  logic         stk_empty;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;

  modport master (
    input  tok_valid, tok_is_op, tok_data, stk_dout, stk_full, stk_empty, res_ready,
    output tok_ready, stk_en, stk_rw, stk_din, res_valid, res_data, res_err
  );

  modport slave (
    output tok_valid, tok_is_op, tok_data, stk_dout, stk_full, stk_empty, res_ready,
    input  tok_ready, stk_en, stk_rw, stk_din, res_valid, res_data, res_err
  );
endinterface

// File: rtl/rpn_stack_master.sv
// Evaluates a reverse-Polish token stream on an external LIFO, tracking depth locally
// so no illegal push/pop is ever issued, and returns the final value via valid/ready.
module rpn_stack_master #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  rpn_stack_master_if.master bus
);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  localparam logic [W-1:0] OP_ADD = W'(0);
  localparam logic [W-1:0] OP_SUB = W'(1);
  localparam logic [W-1:0] OP_AND = W'(2);
  localparam logic [W-1:0] OP_OR  = W'(3);
  localparam logic [W-1:0] OP_XOR = W'(4);
  localparam logic [W-1:0] OP_END = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_POP_B, S_POP_A, S_CAP_A,
    S_PUSH_R, S_POP_F, S_CAP_F, S_RESULT, S_FLUSH
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] depth, depth_n;
  logic          err, err_n;
  logic [W-1:0]  op_q, op_n;
  logic [W-1:0]  b_q, b_n;
  logic [W-1:0]  alu;

  logic          tok_ready;
  logic          stk_en, en_n;
  logic          stk_rw, rw_n;
  logic [W-1:0]  stk_din, din_n;
  logic          res_valid;
  logic [W-1:0]  res_data, res_data_n;
  logic          res_err, res_err_n;

  // A is the freshly popped deeper operand, B was captured one cycle earlier.
  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = bus.stk_dout + b_q;
      OP_SUB:  alu = bus.stk_dout - b_q;
      OP_AND:  alu = bus.stk_dout & b_q;
      OP_OR:   alu = bus.stk_dout | b_q;
      OP_XOR:  alu = bus.stk_dout ^ b_q;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    depth_n    = depth;
    err_n      = err;
    op_n       = op_q;
    b_n        = b_q;
    din_n      = '0;
    res_data_n = res_data;
    res_err_n  = res_err;
    en_n       = 1'b0;
    rw_n       = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.tok_valid && tok_ready) begin
          if (!bus.tok_is_op) begin
            if ((depth < DW'(DEPTH)) && !bus.stk_full) begin
              din_n   = bus.tok_data;
              state_n = S_PUSH;
            end else begin
              err_n = 1'b1;
            end
          end else if (bus.tok_data == OP_END) begin
            if (depth != '0) begin
              state_n = S_POP_F;
            end else begin
              res_data_n = '0;
              res_err_n  = 1'b1;
              state_n    = S_RESULT;
            end
          end else if (bus.tok_data <= OP_XOR) begin
            if (depth >= DW'(2)) begin
              op_n    = bus.tok_data;
              state_n = S_POP_B;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_PUSH, S_PUSH_R: begin
        depth_n = depth + DW'(1);
        if (bus.stk_full) err_n = 1'b1;
        state_n = S_IDLE;
      end
      S_POP_B: begin
        depth_n = depth - DW'(1);
        if (bus.stk_empty) err_n = 1'b1;
        state_n = S_POP_A;
      end
      S_POP_A: begin
        depth_n = depth - DW'(1);
        if (bus.stk_empty) err_n = 1'b1;
        b_n     = bus.stk_dout;
        state_n = S_CAP_A;
      end
      S_CAP_A: begin
        din_n   = alu;
        state_n = S_PUSH_R;
      end
      S_POP_F: begin
        depth_n = depth - DW'(1);
        if (bus.stk_empty) err_n = 1'b1;
        state_n = S_CAP_F;
      end
      S_CAP_F: begin
        res_data_n = bus.stk_dout;
        res_err_n  = err | (depth != '0);
        state_n    = S_RESULT;
      end
      S_RESULT: begin
        if (bus.res_ready) begin
          err_n   = 1'b0;
          state_n = (depth != '0) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        depth_n = depth - DW'(1);
        if (bus.stk_empty) err_n = 1'b1;
        if (depth == DW'(1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Stack command outputs follow the state being entered.
    case (state_n)
      S_PUSH, S_PUSH_R: begin
        en_n = 1'b1;
        rw_n = 1'b0;
      end
      S_POP_B, S_POP_A, S_POP_F, S_FLUSH: begin
        en_n = 1'b1;
        rw_n = 1'b1;
      end
      default: begin
        en_n = 1'b0;
        rw_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      depth     <= '0;
      err       <= 1'b0;
      op_q      <= '0;
      b_q       <= '0;
      tok_ready <= 1'b1;
      stk_en    <= 1'b0;
      stk_rw    <= 1'b0;
      stk_din   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_n;
      depth     <= depth_n;
      err       <= err_n;
      op_q      <= op_n;
      b_q       <= b_n;
      tok_ready <= (state_n == S_IDLE);
      stk_en    <= en_n;
      stk_rw    <= rw_n;
      stk_din   <= din_n;
      res_valid <= (state_n == S_RESULT);
      res_data  <= res_data_n;
      res_err   <= res_err_n;
    end
  end

  assign bus.tok_ready = tok_ready;
  assign bus.stk_en    = stk_en;
  assign bus.stk_rw    = stk_rw;
  assign bus.stk_din   = stk_din;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_err   = res_err;
endmodule

// File: tb/tb_rpn_stack_master.sv
// Random and directed RPN streams against a behavioural LIFO and a queue-based evaluator;
// checks results, per-token cycle cost, stack command counts and reset behaviour.
module tb_rpn_stack_master;
  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int TOK_END = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpn_stack_master_if #(.W(W)) bus ();

  rpn_stack_master #(.DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural LIFO with the same synchronous reset.
  logic [W-1:0] mem [DEPTH];
  int sp = 0;
  int push_cnt = 0;
  int pop_cnt = 0;

  assign bus.stk_full  = (sp == DEPTH);
  assign bus.stk_empty = (sp == 0);

  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      bus.stk_dout <= '0;
    end else if (bus.stk_en) begin
      if (!bus.stk_rw) begin
        push_cnt <= push_cnt + 1;
        if (sp < DEPTH) begin
          mem[sp[3:0]] <= bus.stk_din;
          sp <= sp + 1;
        end
      end else begin
        pop_cnt <= pop_cnt + 1;
        if (sp > 0) begin
          bus.stk_dout <= mem[4'(sp - 1)];
          sp <= sp - 1;
        end
      end
    end
  end

  // Reference evaluator state.
  int ms[$];
  bit merr = 0;
  int exp_push = 0, exp_pop = 0;
  int base_push = 0, base_pop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rebase();
    base_push = push_cnt;
    base_pop  = pop_cnt;
    exp_push  = 0;
    exp_pop   = 0;
  endtask

  // Hand one token over; n = edges from accept until ready again (or res_valid for END).
  task automatic drive_tok(input bit is_op, input logic [W-1:0] d, input bit is_end, output int n);
    int w = 0;
    @(negedge clk);
    bus.tok_valid = 1'b1;
    bus.tok_is_op = is_op;
    bus.tok_data  = d;
    while (!bus.tok_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 32'(w < 100), 1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.tok_valid = 1'b0;
    while (!(is_end ? bus.res_valid : bus.tok_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic get_result(input logic [W-1:0] ed, input logic ee);
    int stall = $urandom_range(0, 3);
    int n = 0;
    check("res_data", 32'(bus.res_data), 32'(ed));
    check("res_err", 32'(bus.res_err), 32'(ee));
    repeat (stall) begin
      @(negedge clk);
      check("res_hold", {bus.res_valid, bus.res_err, bus.res_data}, {1'b1, ee, ed});
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_drop", 32'(bus.res_valid), 0);
    while (!bus.tok_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("back_idle", 32'(bus.tok_ready), 1);
    check("lifo_empty", 32'(sp), 0);
    check("pushes", 32'(push_cnt - base_push), 32'(exp_push));
    check("pops", 32'(pop_cnt - base_pop), 32'(exp_pop));
    rebase();
  endtask

  // Tokens: 0..15 operand, 16+opcode for operator/END.
  task automatic tok(input int t);
    bit is_op = (t >= 16);
    logic [W-1:0] d = 4'(t);
    bit is_end = is_op && (d == 4'hF);
    int exp_cost, n, a, b, r;
    logic [W-1:0] ed;
    logic ee;
    ed = '0;
    ee = 1'b0;
    if (!is_op) begin
      if (ms.size() < DEPTH) begin
        ms.push_back(int'(d));
        exp_push++;
        exp_cost = 2;
      end else begin
        merr = 1;
        exp_cost = 1;
      end
    end else if (is_end) begin
      if (ms.size() == 0) begin
        ed = '0;
        ee = 1'b1;
        exp_cost = 1;
      end else begin
        ed = 4'(ms.pop_back());
        ee = merr || (ms.size() != 0);
        exp_pop += 1 + ms.size();
        ms.delete();
        exp_cost = 3;
      end
    end else if (d <= 4 && ms.size() >= 2) begin
      b = ms.pop_back();
      a = ms.pop_back();
      case (d)
        4'd0: r = a + b;
        4'd1: r = a - b;
        4'd2: r = a & b;
        4'd3: r = a | b;
        default: r = a ^ b;
      endcase
      ms.push_back(r & 15);
      exp_pop += 2;
      exp_push++;
      exp_cost = 5;
    end else begin
      merr = 1;
      exp_cost = 1;
    end
    drive_tok(is_op, d, is_end, n);
    check(is_end ? "end_latency" : "tok_cost", 32'(n), 32'(exp_cost));
    if (is_end) begin
      if (n < 100) get_result(ed, ee);
      merr = 0;
    end
  endtask

  initial begin
    int n;
    bus.tok_valid = 1'b0;
    bus.tok_is_op = 1'b0;
    bus.tok_data  = '0;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_stk", {bus.stk_en, bus.stk_rw, bus.stk_din}, 0);
    check("rst_res", {bus.res_valid, bus.res_err, bus.res_data}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.tok_ready), 1);
    rebase();

    // 3 4 ADD END
    tok(3); tok(4); tok(16); tok(TOK_END);
    // 2 5 SUB END
    tok(2); tok(5); tok(17); tok(TOK_END);
    // 6 3 9 AND END: one leftover entry
    tok(6); tok(3); tok(9); tok(18); tok(TOK_END);
    // 17 operands then END
    for (int i = 0; i < 17; i++) tok(i & 15);
    tok(TOK_END);
    // underflowing ADD, illegal opcode, empty END
    tok(16); tok(16 + 7); tok(TOK_END);

    // Reset during PUSH_R of 1 1 ADD
    tok(1); tok(1);
    @(negedge clk);
    bus.tok_valid = 1'b1;
    bus.tok_is_op = 1'b1;
    bus.tok_data  = 4'd0;
    @(posedge clk);
    @(negedge clk);
    bus.tok_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pushr_cmd", {bus.stk_en, bus.stk_rw, bus.stk_din}, {1'b1, 1'b0, 4'd2});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_stk_en", 32'(bus.stk_en), 0);
    check("abort_ready", 32'(bus.tok_ready), 1);
    check("abort_lifo", 32'(sp), 0);
    ms.delete();
    merr = 0;
    rebase();
    tok(5); tok(TOK_END);

    // Random streams
    for (int s = 0; s < 30; s++) begin
      int len = (s % 6 == 5) ? $urandom_range(16, 22) : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 99);
        int t;
        if (s % 6 == 5 || r < 55) t = $urandom_range(0, 15);
        else if (r < 88) t = 16 + $urandom_range(0, 4);
        else t = 16 + $urandom_range(5, 14);
        tok(t);
      end
      tok(TOK_END);
    end

    n = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
